bignum_operand_streamer: RTL and testbench
==========================================

Name: bignum_operand_streamer

Overview:
- Transmit-side partner of the streaming big-number multiplier.
- Buffers two BITS_IN_NUM-bit operands (n, m), loaded word-by-word from an upstream source such as a UART or control path.
- On command, waits for the multiplier's ready, then streams both operands LSB-block first as one contiguous valid burst.
- Afterwards it tracks the multiplier's product stream until the final flag, then reports completion and any beat-count error.

Parameters:
REGISTER_SIZE, 32, width of one block/word.
BITS_IN_NUM, 4096, operand width in bits; must be a multiple of REGISTER_SIZE.
BLOCKS (localparam), BITS_IN_NUM/REGISTER_SIZE, blocks per operand.
ADDR_WIDTH (localparam), $clog2(BLOCKS), load address width.

Ports:
clk_in  input  1  system clock
rst_in  input  1  asynchronous, active-high reset
load_valid_in  input  1  write one operand word this cycle
load_sel_in  input  1  0 = n buffer, 1 = m buffer
load_addr_in  input  ADDR_WIDTH  block index (0 = least significant)
load_data_in  input  REGISTER_SIZE  block data
start_in  input  1  request a multiplication of buffered operands
mult_ready_in  input  1  multiplier ready (idle)
n_out  output  REGISTER_SIZE  n block to multiplier
m_out  output  REGISTER_SIZE  m block to multiplier
valid_out  output  1  n_out/m_out valid
product_valid_in  input  1  multiplier product beat valid
product_final_in  input  1  multiplier product stream finished
busy_out  output  1  high in any state except IDLE
done_out  output  1  one-cycle pulse when product stream finishes
error_out  output  1  product beat count mismatch; sticky
product_count_out  output  ADDR_WIDTH+2  product beats counted in current run

Behaviour:
- Reset (async assert, sync release): state IDLE; n_out=m_out=0, valid_out=0, done_out=0, error_out=0, product_count_out=0; buffer contents undefined.
- All outputs are registered.
- Two BLOCKS-deep buffers (BRAM or registers) with a 1-cycle registered read; read address is prefetched so the burst has no gaps.
- IDLE:
  - load_valid_in writes load_data_in to buffer[load_sel_in][load_addr_in].
  - start_in -> WAIT_READY; clear error_out and product_count_out.
- WAIT_READY:
  - Hold valid_out=0 until mult_ready_in=1 is sampled, then -> STREAM.
  - start_in and loads are ignored.
- STREAM:
  - valid_out=1 for exactly BLOCKS consecutive cycles.
  - Cycle k (k=0..BLOCKS-1) presents n_out=n[k], m_out=m[k].
  - First valid cycle is at most 2 cycles after mult_ready_in is sampled.
  - Next cycle: valid_out=0, n_out=m_out=0, -> WAIT_RESULT.
  - mult_ready_in is ignored once the burst starts; it drops as expected.
- WAIT_RESULT:
  - product_count_out increments on each product_valid_in beat, saturating at all-ones.
  - When product_final_in=1, the beat coinciding with it is not counted.
    - done_out pulses for one cycle.
    - error_out <= (count != 2*BLOCKS).
    - -> IDLE.
- product_valid_in and product_final_in are ignored outside WAIT_RESULT.
- Loads while busy_out=1 are dropped, so buffers are never modified mid-burst.
- start_in while busy is ignored.
- start_in and load_valid_in in the same IDLE cycle: the load is performed and the start is taken. The burst uses the updated word.
- Reset mid-burst: valid_out drops immediately (async) and the state returns to IDLE. The multiplier must also be reset by the system, because this block does not recover a partially sent burst.

Test Plan:
- Params REGISTER_SIZE=32, BITS_IN_NUM=128 (BLOCKS=4). Load n={1,2,3,4}, m={5,6,7,8}, start with mult_ready_in=1 -> valid_out high exactly 4 consecutive cycles carrying (1,5),(2,6),(3,7),(4,8), then low.
- Start with mult_ready_in=0 for 10 cycles, then 1 -> valid_out stays 0 for those 10 cycles, then a burst starts within 2 cycles; busy_out=1 throughout.
- After the burst, drive 8 product_valid_in beats, then product_final_in -> done_out pulses once, error_out=0, product_count_out=8, busy_out=0 next cycle.
- Same as above with 7 beats -> done_out pulses, error_out=1 and it remains 1 until the next start_in.
- Load n[0]=0xDEAD while in STREAM, run a second multiplication -> both bursts show the original n[0]; the dropped load has no effect.
- Assert rst_in asynchronously at burst cycle 2 -> valid_out=0 before the next clock edge, state IDLE, done_out never pulses.
- Back-to-back runs: start_in on the cycle after done_out -> second burst correct, product_count_out restarts at 0.

Source files
------------

// File: rtl/bignum_operand_streamer.sv
// bignum_operand_streamer: buffers two big-number operands and streams them LSB-block first
// to the multiplier, then counts product beats until the final flag and reports completion.
module bignum_operand_streamer #(
    parameter int REGISTER_SIZE = 32,
    parameter int BITS_IN_NUM = 4096,
    localparam int BLOCKS = BITS_IN_NUM / REGISTER_SIZE,
    localparam int ADDR_WIDTH = $clog2(BLOCKS)
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     load_valid_in,
    input  logic                     load_sel_in,
    input  logic [ADDR_WIDTH-1:0]    load_addr_in,
    input  logic [REGISTER_SIZE-1:0] load_data_in,
    input  logic                     start_in,
    input  logic                     mult_ready_in,
    output logic [REGISTER_SIZE-1:0] n_out,
    output logic [REGISTER_SIZE-1:0] m_out,
    output logic                     valid_out,
    input  logic                     product_valid_in,
    input  logic                     product_final_in,
    output logic                     busy_out,
    output logic                     done_out,
    output logic                     error_out,
    output logic [ADDR_WIDTH+1:0]    product_count_out
);
    localparam logic [1:0] S_IDLE = 2'd0, S_WAIT_READY = 2'd1, S_STREAM = 2'd2, S_WAIT_RESULT = 2'd3;
    logic [REGISTER_SIZE-1:0] r_n_mem [BLOCKS];
    logic [REGISTER_SIZE-1:0] r_m_mem [BLOCKS];
    logic [1:0]               r_state;
    logic [ADDR_WIDTH:0]      r_idx;
    logic                     w_load;
    logic                     w_last;
    logic                     w_count_max;
    logic [ADDR_WIDTH-1:0]    w_rd_addr;
    assign w_load = load_valid_in && r_state == S_IDLE;
    assign w_last = r_idx == (ADDR_WIDTH+1)'(BLOCKS);
    assign w_count_max = &product_count_out;
    assign w_rd_addr = r_idx[ADDR_WIDTH-1:0];
    always_ff @(posedge clk_in) begin
        if (w_load) begin
            if (load_sel_in) r_m_mem[load_addr_in] <= load_data_in;
            else r_n_mem[load_addr_in] <= load_data_in;
        end
    end
    // r_idx holds the next block to read, so the registered read keeps the burst gap-free
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state <= S_IDLE;
            r_idx <= '0;
            n_out <= '0;
            m_out <= '0;
            valid_out <= 1'b0;
            busy_out <= 1'b0;
            done_out <= 1'b0;
            error_out <= 1'b0;
            product_count_out <= '0;
        end else begin
            done_out <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start_in) begin
                        r_state <= S_WAIT_READY;
                        busy_out <= 1'b1;
                        error_out <= 1'b0;
                        product_count_out <= '0;
                    end
                end
                S_WAIT_READY: begin
                    if (mult_ready_in) begin
                        r_state <= S_STREAM;
                        valid_out <= 1'b1;
                        n_out <= r_n_mem[0];
                        m_out <= r_m_mem[0];
                        r_idx <= (ADDR_WIDTH+1)'(1);
                    end
                end
                S_STREAM: begin
                    if (w_last) begin
                        r_state <= S_WAIT_RESULT;
                        valid_out <= 1'b0;
                        n_out <= '0;
                        m_out <= '0;
                    end else begin
                        n_out <= r_n_mem[w_rd_addr];
                        m_out <= r_m_mem[w_rd_addr];
                        r_idx <= r_idx + (ADDR_WIDTH+1)'(1);
                    end
                end
                default: begin
                    if (product_final_in) begin
                        r_state <= S_IDLE;
                        busy_out <= 1'b0;
                        done_out <= 1'b1;
                        error_out <= product_count_out != (ADDR_WIDTH+2)'(2 * BLOCKS);
                    end else if (product_valid_in && !w_count_max) begin
                        product_count_out <= product_count_out + (ADDR_WIDTH+2)'(1);
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bignum_operand_streamer.sv
// tb_bignum_operand_streamer: randomized checks of operand bursts and product accounting
// against an array-based model of the operand buffers and a plain beat counter.
module tb_bignum_operand_streamer;
    localparam int RS = 32;
    localparam int B = 4;
    localparam int AW = 2;
    logic          clk_in = 1'b0;
    logic          rst_in = 1'b1;
    logic          load_valid_in = 1'b0;
    logic          load_sel_in = 1'b0;
    logic [AW-1:0] load_addr_in = '0;
    logic [RS-1:0] load_data_in = '0;
    logic          start_in = 1'b0;
    logic          mult_ready_in = 1'b0;
    logic [RS-1:0] n_out;
    logic [RS-1:0] m_out;
    logic          valid_out;
    logic          product_valid_in = 1'b0;
    logic          product_final_in = 1'b0;
    logic          busy_out;
    logic          done_out;
    logic          error_out;
    logic [AW+1:0] product_count_out;
    int            total = 0;
    int            bad = 0;
    logic [RS-1:0] ref_n [B];
    logic [RS-1:0] ref_m [B];

    bignum_operand_streamer #(.REGISTER_SIZE(RS), .BITS_IN_NUM(RS * B)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .load_valid_in(load_valid_in), .load_sel_in(load_sel_in),
        .load_addr_in(load_addr_in), .load_data_in(load_data_in), .start_in(start_in),
        .mult_ready_in(mult_ready_in), .n_out(n_out), .m_out(m_out), .valid_out(valid_out),
        .product_valid_in(product_valid_in), .product_final_in(product_final_in), .busy_out(busy_out),
        .done_out(done_out), .error_out(error_out), .product_count_out(product_count_out)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic load_word(input logic sel, input int addr, input logic [RS-1:0] data, input bit model);
        load_valid_in = 1'b1;
        load_sel_in = sel;
        load_addr_in = AW'(addr);
        load_data_in = data;
        tick();
        load_valid_in = 1'b0;
        if (model) begin
            if (sel) ref_m[addr] = data;
            else ref_n[addr] = data;
        end
    endtask

    task automatic load_random();
        for (int i = 0; i < B; i++) begin
            load_word(1'b0, i, $urandom, 1'b1);
            load_word(1'b1, i, $urandom, 1'b1);
        end
    endtask

    task automatic do_start(input logic ready);
        start_in = 1'b1;
        mult_ready_in = ready;
        tick();
        start_in = 1'b0;
        total++;
        if ({busy_out, error_out, product_count_out} !== {1'b1, 1'b0, 4'd0}) begin
            bad++;
            $display("FAIL start busy/err/cnt=%b/%b/%0d expected 1/0/0", busy_out, error_out, product_count_out);
        end
    endtask

    task automatic expect_burst(input int budget, input int inject_k);
        int w = 0;
        while (valid_out !== 1'b1 && w < budget) begin
            tick();
            w++;
        end
        total++;
        if (valid_out !== 1'b1) begin
            bad++;
            $display("FAIL burst_start valid_out=%b expected 1 within %0d cycles", valid_out, budget);
            return;
        end
        for (int k = 0; k < B; k++) begin
            total++;
            if ({valid_out, n_out, m_out} !== {1'b1, ref_n[k], ref_m[k]}) begin
                bad++;
                $display("FAIL burst_beat%0d v/n/m=%b/%h/%h expected 1/%h/%h", k, valid_out, n_out, m_out, ref_n[k], ref_m[k]);
            end
            if (k == inject_k) begin
                load_valid_in = 1'b1;
                load_sel_in = 1'b0;
                load_addr_in = '0;
                load_data_in = 32'hDEAD;
            end
            tick();
            load_valid_in = 1'b0;
        end
        total++;
        if ({valid_out, n_out, m_out} !== '0) begin
            bad++;
            $display("FAIL burst_end v/n/m=%b/%h/%h expected 0/0/0", valid_out, n_out, m_out);
        end
    endtask

    task automatic finish_products(input int beats, input bit final_beat, input bit b2b);
        int exp_cnt = 0;
        logic exp_err;
        mult_ready_in = 1'b0;
        for (int i = 0; i < beats; i++) begin
            product_valid_in = 1'b1;
            tick();
            product_valid_in = 1'b0;
            if ($urandom_range(0, 2) == 0) tick();
            exp_cnt = exp_cnt < 15 ? exp_cnt + 1 : 15;
        end
        exp_err = exp_cnt != 2 * B;
        total++;
        if (product_count_out !== 4'(exp_cnt)) begin
            bad++;
            $display("FAIL count_before_final cnt=%0d expected %0d", product_count_out, exp_cnt);
        end
        product_final_in = 1'b1;
        product_valid_in = final_beat;
        tick();
        product_final_in = 1'b0;
        product_valid_in = 1'b0;
        total++;
        if ({done_out, busy_out, error_out, product_count_out} !== {1'b1, 1'b0, exp_err, 4'(exp_cnt)}) begin
            bad++;
            $display("FAIL final done/busy/err/cnt=%b/%b/%b/%0d expected 1/0/%b/%0d",
                     done_out, busy_out, error_out, product_count_out, exp_err, exp_cnt);
        end
        if (b2b) start_in = 1'b1;
        tick();
        start_in = 1'b0;
        total++;
        if (b2b ? {done_out, busy_out, error_out, product_count_out} !== {1'b0, 1'b1, 1'b0, 4'd0}
                : {done_out, busy_out, error_out} !== {1'b0, 1'b0, exp_err}) begin
            bad++;
            $display("FAIL after_done done/busy/err/cnt=%b/%b/%b/%0d b2b=%0d exp_err=%b",
                     done_out, busy_out, error_out, product_count_out, b2b, exp_err);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk_in);
        #1;
        total++;
        if ({n_out, m_out, valid_out, done_out, error_out, product_count_out} !== '0) begin
            bad++;
            $display("FAIL reset_outputs n/m/v/d/e/c=%h/%h/%b/%b/%b/%0d expected all 0",
                     n_out, m_out, valid_out, done_out, error_out, product_count_out);
        end
        rst_in = 1'b0;
        tick();
        total++;
        if ({busy_out, valid_out} !== 2'b00) begin
            bad++;
            $display("FAIL reset_idle busy/valid=%b/%b expected 0/0", busy_out, valid_out);
        end
    endtask

    task automatic test_basic();
        for (int i = 0; i < B; i++) begin
            load_word(1'b0, i, RS'(i + 1), 1'b1);
            load_word(1'b1, i, RS'(i + 5), 1'b1);
        end
        do_start(1'b1);
        expect_burst(2, -1);
        finish_products(8, 1'b0, 1'b0);
    endtask

    task automatic test_wait_ready();
        load_random();
        start_in = 1'b1;
        mult_ready_in = 1'b0;
        tick();
        start_in = 1'b0;
        load_word(1'b1, 2, $urandom, 1'b0);
        product_valid_in = 1'b1;
        product_final_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            total++;
            if ({valid_out, busy_out} !== 2'b01) begin
                bad++;
                $display("FAIL wait_ready%0d valid/busy=%b/%b expected 0/1", i, valid_out, busy_out);
            end
            tick();
        end
        product_valid_in = 1'b0;
        product_final_in = 1'b0;
        mult_ready_in = 1'b1;
        expect_burst(2, -1);
        finish_products(7, 1'b1, 1'b0);
        repeat (3) tick();
        total++;
        if (error_out !== 1'b1) begin
            bad++;
            $display("FAIL error_sticky error_out=%b expected 1", error_out);
        end
    endtask

    task automatic test_dropped_load();
        do_start(1'b1);
        expect_burst(2, 1);
        finish_products(8, 1'b1, 1'b0);
        do_start(1'b1);
        expect_burst(2, -1);
        finish_products(20, 1'b0, 1'b0);
    endtask

    task automatic test_random_runs();
        repeat (3) begin
            load_random();
            do_start(1'b1);
            expect_burst(2, -1);
            finish_products($urandom_range(5, 10), 1'($urandom_range(0, 1)), 1'b0);
        end
    endtask

    task automatic test_reset_mid();
        int w = 0;
        load_random();
        do_start(1'b1);
        while (valid_out !== 1'b1 && w < 4) begin
            tick();
            w++;
        end
        tick();
        tick();
        total++;
        if ({valid_out, n_out} !== {1'b1, ref_n[2]}) begin
            bad++;
            $display("FAIL pre_reset_beat2 v/n=%b/%h expected 1/%h", valid_out, n_out, ref_n[2]);
        end
        #2 rst_in = 1'b1;
        #1;
        total++;
        if ({valid_out, busy_out, n_out, m_out} !== '0) begin
            bad++;
            $display("FAIL async_reset v/busy/n/m=%b/%b/%h/%h expected all 0", valid_out, busy_out, n_out, m_out);
        end
        tick();
        rst_in = 1'b0;
        product_final_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if ({done_out, valid_out, busy_out} !== 3'b000) begin
                bad++;
                $display("FAIL post_reset%0d done/valid/busy=%b/%b/%b expected 0/0/0", i, done_out, valid_out, busy_out);
            end
        end
        product_final_in = 1'b0;
    endtask

    task automatic test_back_to_back();
        load_random();
        do_start(1'b1);
        expect_burst(2, -1);
        finish_products(6, 1'b0, 1'b1);
        mult_ready_in = 1'b1;
        expect_burst(2, -1);
        finish_products($urandom_range(0, 12), 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wait_ready();
        test_dropped_load();
        test_random_runs();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
